fp_classify_round_stage: RTL and testbench

- Registered helper stage for the parametrizable floating-point datapath.
- Classifies one packed float operand as infinite, zero, signaling NaN, quiet NaN or subnormal.
- In the same stage, rounds a pre-normalised exponent/mantissa pair using extra low-order rounding bits.
- Sits after the mantissa product/normalise step of the arithmetic units; latency 1 cycle.

---
 rtl/fp_pkg.sv | 25 ++
 rtl/fp_rounding_core.sv | 58 +++++
 rtl/fp_classify_round_stage.sv | 129 ++++++++++++
 tb/tb_fp_classify_round_stage.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared types and helpers for the parametrizable floating-point datapath.
package fp_pkg;

  localparam int DefaultExponentWidth = 8;
  localparam int DefaultMantissaWidth = 23;
  localparam int FloatBitWidth        = DefaultExponentWidth + DefaultMantissaWidth + 1;

  typedef struct packed {
    logic infinite;
    logic zero;
    logic snan;
    logic qnan;
    logic subnormal;
  } fp_flags_t;

  // E4M3 has no infinity and a single NaN encoding, so it needs its own rules.
  function automatic bit is_e4m3(input int exponent_width, input int mantissa_width);
    return (exponent_width == 4) && (mantissa_width == 3);
  endfunction

  function automatic int float_bit_width(input int exponent_width, input int mantissa_width);
    return exponent_width + mantissa_width + 1;
  endfunction

endpackage

// File: rtl/fp_rounding_core.sv
// Combinational round-to-nearest-even / truncate increment with exponent
// carry and overflow saturation.
module fp_rounding_core
  import fp_pkg::*;
#(
  parameter int EXPONENT_WIDTH                = 8,
  parameter int MANTISSA_WIDTH                = 23,
  parameter int ROUNDING_BITS                 = MANTISSA_WIDTH + 1,
  parameter int ROUND_TO_NEAREST_TIES_TO_EVEN = 1
) (
  input  logic [EXPONENT_WIDTH-1:0] i_exponent,
  input  logic [MANTISSA_WIDTH-1:0] i_mantissa,
  input  logic [ROUNDING_BITS-1:0]  i_rounding_bits,
  output logic [EXPONENT_WIDTH-1:0] o_exponent,
  output logic [MANTISSA_WIDTH-1:0] o_mantissa,
  output logic                      o_overflow
);

  localparam int                        SumWidth = EXPONENT_WIDTH + MANTISSA_WIDTH + 1;
  localparam bit                        IsE4m3   = is_e4m3(EXPONENT_WIDTH, MANTISSA_WIDTH);
  localparam logic [EXPONENT_WIDTH-1:0] Emax     = '1;

  logic                w_round_bit;
  logic                w_sticky;
  logic                w_increment;
  logic [SumWidth-1:0] w_sum;

  assign w_round_bit = i_rounding_bits[ROUNDING_BITS-1];
  assign w_sticky    = |i_rounding_bits[ROUNDING_BITS-2:0];
  assign w_increment = (ROUND_TO_NEAREST_TIES_TO_EVEN != 0) && w_round_bit &&
                       (w_sticky || i_mantissa[0]);

  // Exponent and mantissa added as one word so a mantissa carry bumps the exponent.
  assign w_sum = {1'b0, i_exponent, i_mantissa} + SumWidth'(w_increment);

  // NOTE: every output gets a default first, so no path can infer a latch.
  always_comb begin
    o_exponent = i_exponent;
    o_mantissa = i_mantissa;
    o_overflow = 1'b0;
    if (IsE4m3) begin
      if (w_increment) begin
        // Landing on S.1111.111 (the NaN) or past it saturates to max normal.
        if (w_sum[SumWidth-1] || (&w_sum[SumWidth-2:0])) begin
          o_exponent = '1;
          o_mantissa = {{(MANTISSA_WIDTH-1){1'b1}}, 1'b0};
          o_overflow = 1'b1;
        end else begin
          {o_exponent, o_mantissa} = w_sum[SumWidth-2:0];
        end
      end
    end else if (w_increment && (i_exponent != Emax)) begin
      {o_exponent, o_mantissa} = w_sum[SumWidth-2:0];
      o_overflow = (w_sum[SumWidth-2:MANTISSA_WIDTH] == Emax);
    end
  end

endmodule

// File: rtl/fp_classify_round_stage.sv
// One-cycle registered stage: classifies operand a and rounds a pre-normalised
// exponent/mantissa pair. Optional inexact_flag output under FP_INEXACT_FLAG_EN.
module fp_classify_round_stage
  import fp_pkg::*;
#(
  parameter int EXPONENT_WIDTH                = DefaultExponentWidth,
  parameter int MANTISSA_WIDTH                = DefaultMantissaWidth,
  parameter int ROUND_TO_NEAREST_TIES_TO_EVEN = 1,
  parameter int IGNORE_SIGN_BIT_FOR_NAN       = 1,
  parameter int ROUNDING_BITS                 = MANTISSA_WIDTH + 1,
  localparam int FloatWidth = float_bit_width(EXPONENT_WIDTH, MANTISSA_WIDTH)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  input  logic [FloatWidth-1:0]     a,
  input  logic [EXPONENT_WIDTH-1:0] non_rounded_exponent,
  input  logic [MANTISSA_WIDTH-1:0] non_rounded_mantissa,
  input  logic [ROUNDING_BITS-1:0]  rounding_bits,
  output logic                      out_valid,
  output logic                      is_infinite,
  output logic                      is_zero,
  output logic                      is_signaling_nan,
  output logic                      is_quiet_nan,
  output logic                      is_subnormal,
  output logic [EXPONENT_WIDTH-1:0] rounded_exponent,
  output logic [MANTISSA_WIDTH-1:0] rounded_mantissa,
  output logic                      overflow_flag
`ifdef FP_INEXACT_FLAG_EN
  ,
  output logic                      inexact_flag
`endif
);

  localparam bit IsE4m3 = is_e4m3(EXPONENT_WIDTH, MANTISSA_WIDTH);

  logic                      w_sign;
  logic [EXPONENT_WIDTH-1:0] w_exp;
  logic [MANTISSA_WIDTH-1:0] w_man;
  logic                      w_exp_zero;
  logic                      w_exp_max;
  logic                      w_man_zero;
  logic                      w_nan_sign_ok;
  fp_flags_t                 w_flags;
  logic [EXPONENT_WIDTH-1:0] w_rounded_exponent;
  logic [MANTISSA_WIDTH-1:0] w_rounded_mantissa;
  logic                      w_overflow;

  assign {w_sign, w_exp, w_man} = a;
  assign w_exp_zero    = (w_exp == '0);
  assign w_exp_max     = &w_exp;
  assign w_man_zero    = (w_man == '0);
  assign w_nan_sign_ok = (IGNORE_SIGN_BIT_FOR_NAN != 0) || w_sign;

  always_comb begin
    w_flags           = '0;
    w_flags.zero      = w_exp_zero && w_man_zero;
    w_flags.subnormal = w_exp_zero && !w_man_zero;
    if (IsE4m3) begin
      w_flags.qnan = w_exp_max && (&w_man) && w_nan_sign_ok;
    end else begin
      w_flags.infinite = w_exp_max && w_man_zero;
      w_flags.qnan     = w_exp_max && w_man[MANTISSA_WIDTH-1] && w_nan_sign_ok;
      w_flags.snan     = w_exp_max && !w_man[MANTISSA_WIDTH-1] && !w_man_zero && w_nan_sign_ok;
    end
  end

  fp_rounding_core #(
    .EXPONENT_WIDTH               (EXPONENT_WIDTH),
    .MANTISSA_WIDTH               (MANTISSA_WIDTH),
    .ROUNDING_BITS                (ROUNDING_BITS),
    .ROUND_TO_NEAREST_TIES_TO_EVEN(ROUND_TO_NEAREST_TIES_TO_EVEN)
  ) u_rounding_core (
    .i_exponent     (non_rounded_exponent),
    .i_mantissa     (non_rounded_mantissa),
    .i_rounding_bits(rounding_bits),
    .o_exponent     (w_rounded_exponent),
    .o_mantissa     (w_rounded_mantissa),
    .o_overflow     (w_overflow)
  );

  logic                      r_out_valid;
  fp_flags_t                 r_flags;
  logic [EXPONENT_WIDTH-1:0] r_exponent;
  logic [MANTISSA_WIDTH-1:0] r_mantissa;
  logic                      r_overflow;
`ifdef FP_INEXACT_FLAG_EN
  logic                      r_inexact;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_flags     <= '0;
      r_exponent  <= '0;
      r_mantissa  <= '0;
      r_overflow  <= 1'b0;
`ifdef FP_INEXACT_FLAG_EN
      r_inexact   <= 1'b0;
`endif
    end else begin
      r_out_valid <= in_valid;
      if (in_valid) begin
        r_flags    <= w_flags;
        r_exponent <= w_rounded_exponent;
        r_mantissa <= w_rounded_mantissa;
        r_overflow <= w_overflow;
`ifdef FP_INEXACT_FLAG_EN
        r_inexact  <= |rounding_bits;
`endif
      end
    end
  end

  assign out_valid        = r_out_valid;
  assign is_infinite      = r_flags.infinite;
  assign is_zero          = r_flags.zero;
  assign is_signaling_nan = r_flags.snan;
  assign is_quiet_nan     = r_flags.qnan;
  assign is_subnormal     = r_flags.subnormal;
  assign rounded_exponent = r_exponent;
  assign rounded_mantissa = r_mantissa;
  assign overflow_flag    = r_overflow;
`ifdef FP_INEXACT_FLAG_EN
  assign inexact_flag     = r_inexact;
`endif

endmodule

// File: tb/tb_fp_classify_round_stage.sv
// Self-checking bench: FP32 (default, sign-sensitive NaN, truncate) and E4M3
// instances checked against directed tables and an arithmetic reference model.
module tb_fp_classify_round_stage;

  typedef struct packed {
    logic [4:0]  flags;  // {inf, zero, snan, qnan, sub}
    logic [31:0] e;
    logic [31:0] m;
    logic        ovf;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        v32 = 1'b0;
  logic        v8  = 1'b0;
  logic [31:0] a32 = '0;
  logic [7:0]  e32 = '0;
  logic [22:0] m32 = '0;
  logic [23:0] rb32 = '0;
  logic [7:0]  a8  = '0;
  logic [3:0]  e8  = '0;
  logic [2:0]  m8  = '0;
  logic [3:0]  rb8 = '0;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  wire        ov0, ov1, ov2, ov3;
  wire [4:0]  fl0, fl1, fl2, fl3;
  wire [7:0]  ex0, ex1, ex2;
  wire [22:0] mx0, mx1, mx2;
  wire [3:0]  ex3;
  wire [2:0]  mx3;
  wire        of0, of1, of2, of3;
`ifdef FP_INEXACT_FLAG_EN
  wire        ix0, ix1, ix2, ix3;
`endif

  fp_classify_round_stage u_fp32 (
    .clk(clk), .rst(rst), .in_valid(v32), .a(a32),
    .non_rounded_exponent(e32), .non_rounded_mantissa(m32), .rounding_bits(rb32),
    .out_valid(ov0), .is_infinite(fl0[4]), .is_zero(fl0[3]), .is_signaling_nan(fl0[2]),
    .is_quiet_nan(fl0[1]), .is_subnormal(fl0[0]),
    .rounded_exponent(ex0), .rounded_mantissa(mx0), .overflow_flag(of0)
`ifdef FP_INEXACT_FLAG_EN
    , .inexact_flag(ix0)
`endif
  );

  fp_classify_round_stage #(.IGNORE_SIGN_BIT_FOR_NAN(0)) u_fp32_sign (
    .clk(clk), .rst(rst), .in_valid(v32), .a(a32),
    .non_rounded_exponent(e32), .non_rounded_mantissa(m32), .rounding_bits(rb32),
    .out_valid(ov1), .is_infinite(fl1[4]), .is_zero(fl1[3]), .is_signaling_nan(fl1[2]),
    .is_quiet_nan(fl1[1]), .is_subnormal(fl1[0]),
    .rounded_exponent(ex1), .rounded_mantissa(mx1), .overflow_flag(of1)
`ifdef FP_INEXACT_FLAG_EN
    , .inexact_flag(ix1)
`endif
  );

  fp_classify_round_stage #(.ROUND_TO_NEAREST_TIES_TO_EVEN(0)) u_fp32_trunc (
    .clk(clk), .rst(rst), .in_valid(v32), .a(a32),
    .non_rounded_exponent(e32), .non_rounded_mantissa(m32), .rounding_bits(rb32),
    .out_valid(ov2), .is_infinite(fl2[4]), .is_zero(fl2[3]), .is_signaling_nan(fl2[2]),
    .is_quiet_nan(fl2[1]), .is_subnormal(fl2[0]),
    .rounded_exponent(ex2), .rounded_mantissa(mx2), .overflow_flag(of2)
`ifdef FP_INEXACT_FLAG_EN
    , .inexact_flag(ix2)
`endif
  );

  fp_classify_round_stage #(.EXPONENT_WIDTH(4), .MANTISSA_WIDTH(3)) u_e4m3 (
    .clk(clk), .rst(rst), .in_valid(v8), .a(a8),
    .non_rounded_exponent(e8), .non_rounded_mantissa(m8), .rounding_bits(rb8),
    .out_valid(ov3), .is_infinite(fl3[4]), .is_zero(fl3[3]), .is_signaling_nan(fl3[2]),
    .is_quiet_nan(fl3[1]), .is_subnormal(fl3[0]),
    .rounded_exponent(ex3), .rounded_mantissa(mx3), .overflow_flag(of3)
`ifdef FP_INEXACT_FLAG_EN
    , .inexact_flag(ix3)
`endif
  );

  // Reference model: works on the numeric value exponent*2^mw + mantissa.
  function automatic exp_t model(input int ew, input int mw, input int rbw,
                                 input bit rne, input bit ign,
                                 input logic [31:0] a, input logic [31:0] e_in,
                                 input logic [31:0] m_in, input logic [31:0] rb);
    exp_t        r;
    int unsigned emax, one, ex, mn, v;
    bit          e4, nan_ok, inc;
    emax   = (32'd1 << ew) - 32'd1;
    one    = 32'd1 << mw;
    ex     = (a >> mw) & emax;
    mn     = a % one;
    e4     = (ew == 4) && (mw == 3);
    nan_ok = ign || a[ew+mw];
    r      = '0;
    if (ex == 0) begin
      r.flags = (mn == 0) ? 5'b01000 : 5'b00001;
    end else if (ex == emax) begin
      if (e4) begin
        if (mn == 7 && nan_ok) r.flags = 5'b00010;
      end else if (mn == 0) begin
        r.flags = 5'b10000;
      end else if (nan_ok) begin
        r.flags = (mn >= one / 2) ? 5'b00010 : 5'b00100;
      end
    end
    inc   = rne && rb[rbw-1] && (((rb % (32'd1 << (rbw - 1))) != 0) || m_in[0]);
    r.e   = e_in;
    r.m   = m_in;
    r.ovf = 1'b0;
    if (inc && (e4 || e_in != emax)) begin
      v   = e_in * one + m_in + 32'd1;
      r.e = v / one;
      r.m = v % one;
      if (e4 && v >= 127) begin
        r.e   = 32'd15;
        r.m   = 32'd6;
        r.ovf = 1'b1;
      end else if (!e4 && r.e == emax) begin
        r.ovf = 1'b1;
      end
    end
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; v32 = 1'b1; v8 = 1'b1;
    a32 = 32'h7FC0_0000; e32 = 8'hFE; m32 = '1; rb32 = 24'h80_0000;
    a8 = 8'h7F; e8 = 4'hF; m8 = 3'b110; rb8 = 4'hC;
    step();
    n_vec++;
    if ({ov0, fl0, ex0, mx0, of0, ov1, fl1, ex1, mx1, of1, ov2, fl2, ex2, mx2, of2} !== '0) begin
      n_err++;
      $display("FAIL reset_fp32: got %h required 0",
               {ov0, fl0, ex0, mx0, of0, ov1, fl1, ex1, mx1, of1, ov2, fl2, ex2, mx2, of2});
    end
    n_vec++;
    if ({ov3, fl3, ex3, mx3, of3} !== '0) begin
      n_err++;
      $display("FAIL reset_e4m3: got %h required 0", {ov3, fl3, ex3, mx3, of3});
    end
    rst = 1'b0;
    step();
    n_vec++;
    if ({ov0, fl0} !== {1'b1, 5'b00010}) begin
      n_err++;
      $display("FAIL release_valid: got %b required %b", {ov0, fl0}, {1'b1, 5'b00010});
    end
    v32 = 1'b0; v8 = 1'b0;
    step();
    n_vec++;
    if ({ov0, ov3} !== 2'b00) begin
      n_err++;
      $display("FAIL valid_drop: got %b required 00", {ov0, ov3});
    end
  endtask

  task automatic test_classify();
    logic [31:0] ta   [6] = '{32'h7FC0_0000, 32'h7F80_0001, 32'hFF80_0000,
                              32'h0000_0001, 32'h8000_0000, 32'hFFC0_0000};
    logic [4:0]  tdef [6] = '{5'b00010, 5'b00100, 5'b10000, 5'b00001, 5'b01000, 5'b00010};
    logic [4:0]  tsgn [6] = '{5'b00000, 5'b00000, 5'b10000, 5'b00001, 5'b01000, 5'b00010};
    v32 = 1'b1; e32 = '0; m32 = '0; rb32 = '0;
    for (int i = 0; i < 6; i++) begin
      a32 = ta[i];
      step();
      n_vec++;
      if (fl0 !== tdef[i]) begin
        n_err++;
        $display("FAIL classify_%h: got %b required %b", ta[i], fl0, tdef[i]);
      end
      n_vec++;
      if (fl1 !== tsgn[i]) begin
        n_err++;
        $display("FAIL classify_signed_%h: got %b required %b", ta[i], fl1, tsgn[i]);
      end
    end
  endtask

  task automatic test_rounding();
    logic [7:0]  te  [7] = '{8'h40, 8'h40, 8'h40, 8'h7F, 8'hFE, 8'hFF, 8'h12};
    logic [22:0] tm  [7] = '{23'h000001, 23'h000000, 23'h000000, 23'h7FFFFF,
                             23'h7FFFFF, 23'h123456, 23'h000003};
    logic [23:0] trb [7] = '{24'h800000, 24'h800000, 24'h800001, 24'hC00000,
                             24'h800000, 24'hFFFFFF, 24'h400000};
    logic [7:0]  xe  [7] = '{8'h40, 8'h40, 8'h40, 8'h80, 8'hFF, 8'hFF, 8'h12};
    logic [22:0] xm  [7] = '{23'h000002, 23'h000000, 23'h000001, 23'h000000,
                             23'h000000, 23'h123456, 23'h000003};
    logic        xo  [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    v32 = 1'b1; a32 = 32'h3F80_0000;
    for (int i = 0; i < 7; i++) begin
      e32 = te[i]; m32 = tm[i]; rb32 = trb[i];
      step();
      n_vec++;
      if ({ex0, mx0, of0} !== {xe[i], xm[i], xo[i]}) begin
        n_err++;
        $display("FAIL round_rne_%0d: got e=%h m=%h ovf=%b required e=%h m=%h ovf=%b",
                 i, ex0, mx0, of0, xe[i], xm[i], xo[i]);
      end
      n_vec++;
      if ({ex2, mx2, of2} !== {te[i], tm[i], 1'b0}) begin
        n_err++;
        $display("FAIL round_trunc_%0d: got e=%h m=%h ovf=%b required e=%h m=%h ovf=0",
                 i, ex2, mx2, of2, te[i], tm[i]);
      end
    end
  endtask

  task automatic test_e4m3();
    logic [7:0] ta  [7] = '{8'h7F, 8'h78, 8'hFF, 8'h00, 8'h01, 8'h7E, 8'hF8};
    logic [3:0] te  [7] = '{4'hF, 4'hF, 4'hE, 4'h3, 4'h3, 4'hF, 4'h1};
    logic [2:0] tm  [7] = '{3'd5, 3'd6, 3'd7, 3'd2, 3'd3, 3'd7, 3'd0};
    logic [3:0] trb [7] = '{4'hC, 4'hC, 4'h8, 4'h8, 4'h8, 4'h0, 4'hF};
    logic [4:0] xf  [7] = '{5'b00010, 5'b00000, 5'b00010, 5'b01000, 5'b00001, 5'b00000, 5'b00000};
    logic [3:0] xe  [7] = '{4'hF, 4'hF, 4'hF, 4'h3, 4'h3, 4'hF, 4'h1};
    logic [2:0] xm  [7] = '{3'd6, 3'd6, 3'd0, 3'd2, 3'd4, 3'd7, 3'd1};
    logic       xo  [7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    v8 = 1'b1;
    for (int i = 0; i < 7; i++) begin
      a8 = ta[i]; e8 = te[i]; m8 = tm[i]; rb8 = trb[i];
      step();
      n_vec++;
      if ({fl3, ex3, mx3, of3} !== {xf[i], xe[i], xm[i], xo[i]}) begin
        n_err++;
        $display("FAIL e4m3_%0d: got fl=%b e=%h m=%h ovf=%b required fl=%b e=%h m=%h ovf=%b",
                 i, fl3, ex3, mx3, of3, xf[i], xe[i], xm[i], xo[i]);
      end
    end
    v8 = 1'b0;
  endtask

  task automatic test_hold();
    v32 = 1'b1; a32 = 32'h7F80_0000; e32 = 8'h10; m32 = 23'h5; rb32 = '0;
    step();
    v32 = 1'b0; a32 = '0; e32 = 8'hFE; m32 = '1; rb32 = 24'h80_0000;
    step();
    n_vec++;
    if ({ov0, fl0, ex0, mx0, of0} !== {1'b0, 5'b10000, 8'h10, 23'h5, 1'b0}) begin
      n_err++;
      $display("FAIL hold: got v=%b fl=%b e=%h m=%h ovf=%b required v=0 fl=10000 e=10 m=000005 ovf=0",
               ov0, fl0, ex0, mx0, of0);
    end
  endtask

  task automatic test_random();
    exp_t r0, r1, r2, r3;
    v32 = 1'b1; v8 = 1'b1;
    for (int i = 0; i < 300; i++) begin
      a32 = $urandom;
      case ($urandom_range(0, 3))
        0: a32[30:23] = '1;
        1: a32[30:23] = '0;
        default: ;
      endcase
      e32  = 8'($urandom);
      if ($urandom_range(0, 3) == 0) e32 = 8'hFE;
      m32  = 23'($urandom);
      if ($urandom_range(0, 3) == 0) m32 = '1;
      rb32 = 24'($urandom);
      if ($urandom_range(0, 3) == 0) rb32 = 24'h80_0000;
      a8   = 8'($urandom);
      e8   = 4'($urandom);
      if ($urandom_range(0, 1) == 0) e8 = 4'hF;
      m8   = 3'($urandom);
      rb8  = 4'($urandom);
      r0 = model(8, 23, 24, 1'b1, 1'b1, a32, {24'b0, e32}, {9'b0, m32}, {8'b0, rb32});
      r1 = model(8, 23, 24, 1'b1, 1'b0, a32, {24'b0, e32}, {9'b0, m32}, {8'b0, rb32});
      r2 = model(8, 23, 24, 1'b0, 1'b1, a32, {24'b0, e32}, {9'b0, m32}, {8'b0, rb32});
      r3 = model(4, 3, 4, 1'b1, 1'b1, {24'b0, a8}, {28'b0, e8}, {29'b0, m8}, {28'b0, rb8});
      step();
      n_vec++;
      if ({ov0, fl0, ex0, mx0, of0} !== {1'b1, r0.flags, r0.e[7:0], r0.m[22:0], r0.ovf}) begin
        n_err++;
        $display("FAIL rand_fp32 a=%h e=%h m=%h rb=%h: got fl=%b e=%h m=%h ovf=%b required fl=%b e=%h m=%h ovf=%b",
                 a32, e32, m32, rb32, fl0, ex0, mx0, of0, r0.flags, r0.e[7:0], r0.m[22:0], r0.ovf);
      end
      n_vec++;
      if ({fl1, ex1, mx1, of1} !== {r1.flags, r1.e[7:0], r1.m[22:0], r1.ovf}) begin
        n_err++;
        $display("FAIL rand_fp32_signed a=%h: got fl=%b e=%h m=%h ovf=%b required fl=%b e=%h m=%h ovf=%b",
                 a32, fl1, ex1, mx1, of1, r1.flags, r1.e[7:0], r1.m[22:0], r1.ovf);
      end
      n_vec++;
      if ({fl2, ex2, mx2, of2} !== {r2.flags, r2.e[7:0], r2.m[22:0], r2.ovf}) begin
        n_err++;
        $display("FAIL rand_fp32_trunc e=%h m=%h rb=%h: got e=%h m=%h ovf=%b required e=%h m=%h ovf=%b",
                 e32, m32, rb32, ex2, mx2, of2, r2.e[7:0], r2.m[22:0], r2.ovf);
      end
      n_vec++;
      if ({ov3, fl3, ex3, mx3, of3} !== {1'b1, r3.flags, r3.e[3:0], r3.m[2:0], r3.ovf}) begin
        n_err++;
        $display("FAIL rand_e4m3 a=%h e=%h m=%h rb=%h: got fl=%b e=%h m=%h ovf=%b required fl=%b e=%h m=%h ovf=%b",
                 a8, e8, m8, rb8, fl3, ex3, mx3, of3, r3.flags, r3.e[3:0], r3.m[2:0], r3.ovf);
      end
`ifdef FP_INEXACT_FLAG_EN
      n_vec++;
      if ({ix0, ix2, ix3} !== {|rb32, |rb32, |rb8}) begin
        n_err++;
        $display("FAIL rand_inexact: got %b required %b", {ix0, ix2, ix3}, {|rb32, |rb32, |rb8});
      end
`endif
    end
    v32 = 1'b0; v8 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_classify();
    test_rounding();
    test_e4m3();
    test_hold();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
